// File: rtl/mem_pkg.sv
// Shared types and constants for the mem FIFO controller and its output skid buffer.
package mem_pkg;

    typedef enum logic {
        GNT_WR = 1'b0,
        GNT_RD = 1'b1
    } grant_e;

    localparam int MEM_SKID_DEPTH = 2;

    function automatic int unsigned mem_depth(input int unsigned addr_width);
        return 32'd1 << addr_width;
    endfunction

endpackage

// File: rtl/mem_fifo_ctrl_if.sv
// Streaming push/pop handshakes, status flags and the mem-side access bus of mem_fifo_ctrl.
interface mem_fifo_ctrl_if #(
    parameter int addr_width = 6,
    parameter int bus_width  = 14
);

    logic                  s_valid;
    logic                  s_ready;
    logic [bus_width-1:0]  s_data;
    logic                  m_valid;
    logic                  m_ready;
    logic [bus_width-1:0]  m_data;
    logic [addr_width+1:0] count;
    logic                  full;
    logic                  empty;
    logic                  mem_en;
    logic                  mem_cs;
    logic [addr_width-1:0] mem_addr;
    logic [bus_width-1:0]  mem_din;
    logic [bus_width-1:0]  mem_dout;

    // Environment side: producer, consumer and the mem storage block.
    modport master (
        output s_valid, s_data, m_ready, mem_dout,
        input  s_ready, m_valid, m_data, count, full, empty,
        input  mem_en, mem_cs, mem_addr, mem_din
    );

    // Controller side.
    modport slave (
        input  s_valid, s_data, m_ready, mem_dout,
        output s_ready, m_valid, m_data, count, full, empty,
        output mem_en, mem_cs, mem_addr, mem_din
    );

endinterface

// File: rtl/mem_skid_buf.sv
// Two-entry register FIFO catching mem read data; head entry is presented combinationally.
// Optional synchronous clear when MEM_FIFO_CTRL_FLUSH_EN is defined.
module mem_skid_buf
    import mem_pkg::*;
#(
    parameter int bus_width = 14
) (
    input  logic                 clk,
    input  logic                 rstn,
`ifdef MEM_FIFO_CTRL_FLUSH_EN
    input  logic                 clr_i,
`endif
    input  logic                 push_i,
    input  logic [bus_width-1:0] push_data_i,
    input  logic                 pop_i,
    output logic [bus_width-1:0] head_o,
    output logic [1:0]           occ_o
);

    localparam logic [1:0] FULL_OCC = 2'(MEM_SKID_DEPTH);

    logic [bus_width-1:0] head_q, head_d;
    logic [bus_width-1:0] tail_q, tail_d;
    logic [1:0]           occ_q, occ_d;

    always_comb begin
        // NOTE: every next-state variable gets a default first so no path leaves it unassigned (no latches).
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        unique case ({push_i, pop_i})
            2'b10: begin
                if (occ_q == 2'd0) head_d = push_data_i;
                else               tail_d = push_data_i;
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                head_d = tail_q;
                occ_d  = occ_q - 2'd1;
            end
            2'b11: begin
                if (occ_q == FULL_OCC) begin
                    head_d = tail_q;
                    tail_d = push_data_i;
                end else begin
                    head_d = push_data_i;
                end
            end
            default: ;
        endcase
`ifdef MEM_FIFO_CTRL_FLUSH_EN
        if (clr_i) begin
            head_d = '0;
            tail_d = '0;
            occ_d  = 2'd0;
        end
`endif
    end

    // NOTE: the data entries are plain registers, so they are reset too; that is what makes m_data read 0 out of reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= 2'd0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
        end
    end

    assign head_o = head_q;
    assign occ_o  = occ_q;

endmodule

// File: rtl/mem_fifo_ctrl.sv
// FIFO controller over a single-port mem: round-robin write/read arbitration plus a 2-entry skid buffer.
// Defining MEM_FIFO_CTRL_FLUSH_EN adds a synchronous flush input.
module mem_fifo_ctrl
    import mem_pkg::*;
#(
    parameter int addr_width = 6,
    parameter int bus_width  = 14
) (
    input  logic           clk,
    input  logic           rstn,
`ifdef MEM_FIFO_CTRL_FLUSH_EN
    input  logic           flush,
`endif
    mem_fifo_ctrl_if.slave bus
);

    localparam int             CW    = addr_width + 1;
    localparam logic [CW-1:0]  DEPTH = CW'(mem_depth(addr_width));

    logic [addr_width-1:0] wr_ptr_q, wr_ptr_d;
    logic [addr_width-1:0] rd_ptr_q, rd_ptr_d;
    logic [addr_width-1:0] addr_q, addr_d;
    logic [CW-1:0]         mem_count_q, mem_count_d;
    logic                  rd_inflight_q, rd_inflight_d;
    grant_e                last_grant_q, last_grant_d;

    logic [1:0]            skid_occ;
    logic [bus_width-1:0]  skid_head;
    logic [2:0]            skid_pend;
    logic                  m_valid, pop, full, rd_elig, s_ready, wr, rd;
    logic [addr_width-1:0] mem_addr;

    assign m_valid   = (skid_occ != 2'd0);
    assign pop       = m_valid && bus.m_ready;
    assign full      = (mem_count_q == DEPTH);
    // Slots already committed to the skid once this cycle's pop is taken out.
    assign skid_pend = 3'(skid_occ) + 3'(rd_inflight_q) - 3'(pop);
    assign rd_elig   = (mem_count_q != '0) && (skid_pend < 3'(MEM_SKID_DEPTH));
    // After a write grant an eligible read wins; this gives strict alternation under contention.
    assign s_ready   = rstn && !full && !(rd_elig && last_grant_q == GNT_WR);
    assign wr        = bus.s_valid && s_ready;
    assign rd        = rd_elig && !wr;
    assign mem_addr  = wr ? wr_ptr_q : (rd ? rd_ptr_q : addr_q);

    always_comb begin
        wr_ptr_d      = wr_ptr_q + addr_width'(wr);
        rd_ptr_d      = rd_ptr_q + addr_width'(rd);
        mem_count_d   = mem_count_q + CW'(wr) - CW'(rd);
        rd_inflight_d = rd;
        addr_d        = mem_addr;
        last_grant_d  = last_grant_q;
        if (wr)      last_grant_d = GNT_WR;
        else if (rd) last_grant_d = GNT_RD;
`ifdef MEM_FIFO_CTRL_FLUSH_EN
        if (flush) begin
            wr_ptr_d      = '0;
            rd_ptr_d      = '0;
            mem_count_d   = '0;
            rd_inflight_d = 1'b0;
            addr_d        = '0;
            last_grant_d  = GNT_RD;
        end
`endif
    end

    // Only pointers and bookkeeping clear here; the external mem keeps its stale contents.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            addr_q        <= '0;
            mem_count_q   <= '0;
            rd_inflight_q <= 1'b0;
            last_grant_q  <= GNT_RD;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            addr_q        <= addr_d;
            mem_count_q   <= mem_count_d;
            rd_inflight_q <= rd_inflight_d;
            last_grant_q  <= last_grant_d;
        end
    end

    mem_skid_buf #(
        .bus_width   (bus_width)
    ) u_skid (
        .clk         (clk),
        .rstn        (rstn),
`ifdef MEM_FIFO_CTRL_FLUSH_EN
        .clr_i       (flush),
`endif
        .push_i      (rd_inflight_q),
        .push_data_i (bus.mem_dout),
        .pop_i       (pop),
        .head_o      (skid_head),
        .occ_o       (skid_occ)
    );

    assign bus.s_ready  = s_ready;
    assign bus.m_valid  = m_valid;
    assign bus.m_data   = skid_head;
    assign bus.count    = (addr_width+2)'(mem_count_q) + (addr_width+2)'(rd_inflight_q)
                        + (addr_width+2)'(skid_occ);
    assign bus.full     = full;
    assign bus.empty    = (bus.count == '0);
    assign bus.mem_en   = wr;
    assign bus.mem_cs   = wr || rd;
    assign bus.mem_addr = mem_addr;
    assign bus.mem_din  = bus.s_data;

endmodule

// File: tb/tb_mem_fifo_ctrl.sv
// Randomised and directed bench for mem_fifo_ctrl against a queue model of FIFO order and occupancy.
module tb_mem_fifo_ctrl;

    localparam int AW    = 2;
    localparam int BW    = 14;
    localparam int DEPTH = 1 << AW;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    mem_fifo_ctrl_if #(.addr_width(AW), .bus_width(BW)) bus ();

`ifdef MEM_FIFO_CTRL_FLUSH_EN
    logic flush = 1'b0;
`endif

    mem_fifo_ctrl #(
        .addr_width (AW),
        .bus_width  (BW)
    ) dut (
        .clk   (clk),
        .rstn  (rstn),
`ifdef MEM_FIFO_CTRL_FLUSH_EN
        .flush (flush),
`endif
        .bus   (bus)
    );

    // Single-port storage with one-cycle read latency, standing in for mem.
    logic [BW-1:0] ram [DEPTH];
    logic [BW-1:0] ram_dout = '0;
    always @(posedge clk) begin
        if (bus.mem_cs && bus.mem_en)  ram[bus.mem_addr] <= bus.mem_din;
        if (bus.mem_cs && !bus.mem_en) ram_dout <= ram[bus.mem_addr];
    end
    assign bus.mem_dout = ram_dout;

    int errors = 0;
    int checks = 0;
    logic [BW-1:0] model_q[$];
    int  cyc = 0;
    int  first_rd = -1, first_mv = -1;
    bit  last_push, last_rd, prev_wr;
    int  n_wr, n_rd, consec_wr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock: check and update the model at the falling edge, then move to just after the rising edge.
    task automatic step();
        bit push, pop;
        @(negedge clk);
        push = 1'b0;
        last_rd = 1'b0;
        if (rstn) begin
            check("count", bus.count, model_q.size());
            check("empty", bus.empty, model_q.size() == 0);
            check("mem_din", bus.mem_din, bus.s_data);
            if (bus.full)   check("full_blocks_push", bus.s_ready, 0);
            if (bus.mem_en) check("en_implies_cs", bus.mem_cs, 1);
            push    = bus.s_valid && bus.s_ready;
            pop     = bus.m_valid && bus.m_ready;
            last_rd = bus.mem_cs && !bus.mem_en;
            if (last_rd && first_rd < 0) first_rd = cyc;
            if (bus.m_valid && first_mv < 0) first_mv = cyc;
            if (pop) begin
                if (model_q.size() == 0) check("pop_from_empty", bus.m_valid, 0);
                else                     check("pop_data", bus.m_data, model_q.pop_front());
            end
            if (push && prev_wr) consec_wr++;
            if (push)    n_wr++;
            if (last_rd) n_rd++;
            prev_wr = push;
`ifdef MEM_FIFO_CTRL_FLUSH_EN
            if (flush) begin
                model_q.delete();
                push = 1'b0;
            end
`endif
            if (push) model_q.push_back(bus.s_data);
        end
        last_push = push;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic push_word(input logic [BW-1:0] d);
        int n = 0;
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        last_push   = 1'b0;
        while (!last_push && n < 20) begin
            step();
            n++;
        end
        check("push_accepted", last_push, 1);
        bus.s_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        bus.s_valid = 1'b0;
        bus.m_ready = 1'b1;
        while (model_q.size() != 0 && n < 40) begin
            step();
            n++;
        end
        check("drain_empty", bus.empty, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int waited;
        logic [BW-1:0] d;

        bus.s_valid = 1'b1;
        bus.s_data  = 14'h2AA;
        bus.m_ready = 1'b0;
        #2;
        check("rst_s_ready", bus.s_ready, 0);
        check("rst_m_valid", bus.m_valid, 0);
        check("rst_m_data", bus.m_data, 0);
        check("rst_count", bus.count, 0);
        check("rst_empty", bus.empty, 1);
        check("rst_full", bus.full, 0);
        check("rst_mem_en", bus.mem_en, 0);
        check("rst_mem_cs", bus.mem_cs, 0);
        check("rst_mem_addr", bus.mem_addr, 0);
        bus.s_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // In-order delivery and first-word latency.
        bus.m_ready = 1'b1;
        first_rd = -1;
        first_mv = -1;
        for (int i = 1; i <= 3; i++) push_word(BW'(i));
        repeat (8) step();
        check("latency_rd_to_mvalid", first_mv - first_rd, 2);
        check("seq_empty_end", bus.empty, 1);

        // Fill storage and skid with the consumer stalled.
        bus.m_ready = 1'b0;
        bus.s_valid = 1'b1;
        d = 14'h100;
        bus.s_data = d;
        for (int i = 0; i < 30; i++) begin
            step();
            if (last_push) begin
                d++;
                bus.s_data = d;
            end
        end
        check("fill_count", bus.count, DEPTH + 2);
        check("fill_full", bus.full, 1);
        check("fill_s_ready", bus.s_ready, 0);
        check("fill_m_valid", bus.m_valid, 1);
        check("fill_no_access", bus.mem_cs, 0);
        bus.m_ready = 1'b1;
        waited = 0;
        last_push = 1'b0;
        while (!last_push && waited < 10) begin
            step();
            waited++;
        end
        check("fifth_push_after_pop", (waited >= 1 && waited <= 3), 1);
        drain();

        // Consumer stall mid-stream: skid holds two words and reads stop.
        bus.m_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_word(BW'(14'h200 + i));
        repeat (3) step();
        check("stall_m_valid", bus.m_valid, 1);
        check("stall_no_read", bus.mem_cs, 0);
        check("stall_count", bus.count, 4);
        drain();

        // Continuous push and pop: writes and reads must alternate.
        bus.s_valid = 1'b1;
        bus.m_ready = 1'b1;
        d = 14'h300;
        bus.s_data = d;
        n_wr = 0;
        n_rd = 0;
        consec_wr = 0;
        prev_wr = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (last_push) begin
                d++;
                bus.s_data = d;
            end
        end
        check("contend_no_back_to_back_wr", consec_wr, 0);
        check("contend_wr_share", n_wr >= 9, 1);
        check("contend_rd_share", n_rd >= 9, 1);
        drain();

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            bus.s_valid = ($urandom_range(0, 1) == 1);
            bus.m_ready = ($urandom_range(0, 3) != 0);
            bus.s_data  = BW'($urandom);
            step();
        end
        drain();

        // Asynchronous reset with words stored and a read in flight.
        bus.m_ready = 1'b0;
        for (int i = 0; i < 3; i++) push_word(BW'(14'h3C0 + i));
        #2;
        rstn = 1'b0;
        #1;
        check("midrst_m_valid", bus.m_valid, 0);
        check("midrst_count", bus.count, 0);
        check("midrst_empty", bus.empty, 1);
        model_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        bus.m_ready = 1'b1;
        push_word(14'h02A);
        push_word(14'h02B);
        drain();

`ifdef MEM_FIFO_CTRL_FLUSH_EN
        // Flush while a read is in flight; the stale read data must not surface.
        bus.m_ready = 1'b0;
        push_word(14'h111);
        push_word(14'h222);
        waited = 0;
        last_rd = 1'b0;
        while (!last_rd && waited < 10) begin
            step();
            waited++;
        end
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_empty", bus.empty, 1);
        check("flush_m_valid", bus.m_valid, 0);
        bus.m_ready = 1'b1;
        repeat (3) step();
        check("flush_no_stale", bus.m_valid, 0);
        push_word(14'h333);
        drain();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
